// File: rtl/stage2_pkg.sv
// stage2_pkg: shared lane/beat types and constants for the stage-2 feeder.
package stage2_pkg;
  localparam int WIDTH = 16;
  localparam int PAR = 2;
  localparam int STAGE_W = 3;
  typedef logic [PAR-1:0][WIDTH-1:0] lane_vec_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} feeder_state_e;
  typedef struct packed {
    lane_vec_t operand;
    lane_vec_t scale;
    lane_vec_t pos;
  } beat_t;
endpackage

// File: rtl/stage2_fifo.sv
// stage2_fifo: synchronous beat FIFO, async reset, head reads 0 when empty.
module stage2_fifo
  import stage2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK_i,
  input  logic                   RST_i,
  input  logic                   push,
  input  logic                   pop,
  input  beat_t                  din,
  output logic                   full,
  output logic                   empty,
  output beat_t                  head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  beat_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = empty ? '0 : mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    do_push = push & !full;
    do_pop = pop & !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK_i) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/stage2_feeder.sv
// stage2_feeder: buffers beats for the stage-2 pipe, gates its stall and captures results.
// Optional STAGE2_FEEDER_PERF_EN adds saturating stall/beat counters.
module stage2_feeder
  import stage2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK_i,
  input  logic                   RST_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [PAR*WIDTH-1:0]   in_operand_i,
  input  logic [PAR*WIDTH-1:0]   in_scale_i,
  input  logic [PAR*WIDTH-1:0]   in_pos_i,
  output logic                   stall_o,
  output logic [PAR*WIDTH-1:0]   operand_o,
  output logic [PAR*WIDTH-1:0]   scale_o,
  output logic [PAR*WIDTH-1:0]   pos_o,
  input  logic [STAGE_W-1:0]     stage_i,
  input  logic                   finished_i,
  input  logic [PAR*WIDTH-1:0]   op1_i,
  input  logic [PAR*WIDTH-1:0]   op2_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [PAR*WIDTH-1:0]   res_op1_o,
  output logic [PAR*WIDTH-1:0]   res_op2_o,
  output logic [STAGE_W-1:0]     res_stage_o,
  output logic [7:0]             dropped_o
`ifdef STAGE2_FEEDER_PERF_EN
  ,
  output logic [15:0]            stall_cnt_o,
  output logic [15:0]            beat_cnt_o
`endif
);
  feeder_state_e state_q, state_d;
  logic res_valid_q, res_valid_d;
  logic [PAR*WIDTH-1:0] res_op1_q, res_op1_d, res_op2_q, res_op2_d;
  logic [STAGE_W-1:0] res_stage_q, res_stage_d;
  logic [7:0] dropped_q, dropped_d;
  logic run, flush, go, advance, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_cnt;
  beat_t fifo_head;
  assign run = state_q == RUN;
  assign flush = state_q == FLUSH;
  assign go = state_q == IDLE && start_i;
  // The pipe is combinational on the head, so a step is only taken when its result has a home.
  assign advance = run & !fifo_empty & !(res_valid_q & !res_ready_i) & !finished_i;
  assign fifo_push = in_valid_i & in_ready_o;
  assign fifo_pop = advance | (flush & !fifo_empty);
  stage2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK_i(CLK_i),
    .RST_i(RST_i),
    .push(fifo_push),
    .pop(fifo_pop),
    .din({in_operand_i, in_scale_i, in_pos_i}),
    .full(fifo_full),
    .empty(fifo_empty),
    .head(fifo_head),
    .count(fifo_cnt)
  );
  always_comb begin
    state_d = go ? RUN
            : (run && finished_i) ? FLUSH
            : (flush && fifo_cnt == '0 && !res_valid_q) ? DONE
            : (state_q == DONE) ? IDLE
            : state_q;
    dropped_d = go ? '0 : (flush && !fifo_empty && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    res_valid_d = advance | (res_valid_q & !res_ready_i);
    res_op1_d = advance ? op1_i : res_op1_q;
    res_op2_d = advance ? op2_i : res_op2_q;
    res_stage_d = advance ? stage_i : res_stage_q;
  end
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      res_valid_q <= 1'b0;
      res_op1_q <= '0;
      res_op2_q <= '0;
      res_stage_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      res_valid_q <= res_valid_d;
      res_op1_q <= res_op1_d;
      res_op2_q <= res_op2_d;
      res_stage_q <= res_stage_d;
      dropped_q <= dropped_d;
    end
  end
  assign busy_o = run | flush;
  assign done_o = state_q == DONE;
  assign in_ready_o = !fifo_full & run;
  assign stall_o = !advance;
  assign operand_o = fifo_head.operand;
  assign scale_o = fifo_head.scale;
  assign pos_o = fifo_head.pos;
  assign res_valid_o = res_valid_q;
  assign res_op1_o = res_op1_q;
  assign res_op2_o = res_op2_q;
  assign res_stage_o = res_stage_q;
  assign dropped_o = dropped_q;
`ifdef STAGE2_FEEDER_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, beat_cnt_q, beat_cnt_d;
  always_comb begin
    stall_cnt_d = go ? '0 : (run && !advance && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    beat_cnt_d = go ? '0 : (advance && beat_cnt_q != 16'hFFFF) ? beat_cnt_q + 16'd1 : beat_cnt_q;
  end
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      stall_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign beat_cnt_o = beat_cnt_q;
`endif
endmodule

// File: tb/tb_stage2_feeder.sv
// tb_stage2_feeder: directed stimulus with a queue scoreboard checked by a separate result monitor.
module tb_stage2_feeder;
  import stage2_pkg::*;
  localparam int W = PAR*WIDTH;
  localparam logic [W-1:0] SIGN = {PAR{16'h8000}};
  logic CLK_i = 0, RST_i = 1, start_i = 0, in_valid_i = 0, res_ready_i = 1, finished_i = 0;
  logic [W-1:0] in_operand_i = '0, in_scale_i = '0, in_pos_i = '0;
  logic [W-1:0] op1_i, op2_i, operand_o, scale_o, pos_o, res_op1_o, res_op2_o;
  logic [2:0] stage_i, res_stage_o, stage_v = 0;
  logic busy_o, done_o, in_ready_o, stall_o, res_valid_o;
  logic [7:0] dropped_o;
`ifdef STAGE2_FEEDER_PERF_EN
  logic [15:0] stall_cnt_o, beat_cnt_o;
`endif
  typedef struct packed {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0] stage;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, low_cnt = 0, first_low = -1, push_cyc = 0, res_cnt = 0;

  stage2_feeder #(.DEPTH(4)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_operand_i(in_operand_i),
    .in_scale_i(in_scale_i), .in_pos_i(in_pos_i), .stall_o(stall_o), .operand_o(operand_o),
    .scale_o(scale_o), .pos_o(pos_o), .stage_i(stage_i), .finished_i(finished_i),
    .op1_i(op1_i), .op2_i(op2_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_op1_o(res_op1_o), .res_op2_o(res_op2_o), .res_stage_o(res_stage_o), .dropped_o(dropped_o)
`ifdef STAGE2_FEEDER_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .beat_cnt_o(beat_cnt_o)
`endif
  );

  always #5 CLK_i = ~CLK_i;
  // Stand-in pipe: op1 negates each fp16 lane, op2 mixes scale with pos.
  assign op1_i = operand_o ^ SIGN;
  assign op2_i = scale_o ^ pos_o;
  assign stage_i = stage_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK_i);
    #1;
  endtask

  task automatic send(input logic [W-1:0] op, input logic [W-1:0] sc, input logic [W-1:0] ps,
                      input bit exp, output bit acc);
    exp_t e;
    in_valid_i = 1; in_operand_i = op; in_scale_i = sc; in_pos_i = ps;
    @(negedge CLK_i);
    acc = in_ready_o;
    push_cyc = cyc;
    if (acc && exp) begin
      e.op1 = op ^ SIGN; e.op2 = sc ^ ps; e.stage = stage_v;
      sb.push_back(e);
    end
    @(posedge CLK_i); #1;
    in_valid_i = 0;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_busy"}, busy_o, 0);
    chk({t, "_done"}, done_o, 0);
    chk({t, "_in_ready"}, in_ready_o, 0);
    chk({t, "_stall"}, stall_o, 1);
    chk({t, "_res_valid"}, res_valid_o, 0);
    chk({t, "_res_op1"}, res_op1_o, 0);
    chk({t, "_res_op2"}, res_op2_o, 0);
    chk({t, "_res_stage"}, res_stage_o, 0);
    chk({t, "_dropped"}, dropped_o, 0);
    chk({t, "_head"}, operand_o, 0);
  endtask

  always @(posedge CLK_i) cyc <= cyc + 1;

  always @(negedge CLK_i) begin
    if (!RST_i) begin
      if (done_o) done_cnt++;
      if (!stall_o) begin
        low_cnt++;
        if (first_low < 0) first_low = cyc;
      end
      if (res_valid_o && res_ready_i) begin
        res_cnt++;
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_m = sb.pop_front();
          chk("res_op1", res_op1_o, e_m.op1);
          chk("res_op2", res_op2_o, e_m.op2);
          chk("res_stage", res_stage_o, e_m.stage);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int p0, d0, k;
    step(2);
    @(negedge CLK_i);
    check_reset("rst");
    step(1);
    RST_i = 0;
    // three beats straight through
    start_i = 1; step(1); start_i = 0;
    @(negedge CLK_i);
    chk("t1_busy", busy_o, 1);
    chk("t1_in_ready", in_ready_o, 1);
    step(1);
    low_cnt = 0; first_low = -1;
    send({16'h4000, 16'h3C00}, {16'h3800, 16'h3400}, {16'h0001, 16'h0002}, 1, a);
    p0 = push_cyc;
    send({16'h3C00, 16'h4000}, {16'h3400, 16'h3800}, {16'h0003, 16'h0004}, 1, a);
    send({16'h4000, 16'h4000}, {16'h3C00, 16'h3C00}, {16'h0005, 16'h0006}, 1, a);
    step(4);
    chk("t1_stall_low_cycles", low_cnt, 3);
    chk("t1_first_low_cycle", first_low, p0 + 1);
    chk("t1_results", res_cnt, 3);
    chk("t1_sb_empty", sb.size(), 0);
    // result held, FIFO filled to capacity
    res_ready_i = 0; stage_v = 1;
    send({16'h1111, 16'h2222}, {16'h0F0F, 16'hF0F0}, {16'h00FF, 16'hFF00}, 1, a);
    chk("t2_accept_a", a, 1);
    for (int i = 0; i < 4; i++) begin
      send({16'h5000, 16'(16'h3C00 + i)}, {16'h0100, 16'(i)}, {16'h0010, 16'h0020}, 1, a);
      chk("t2_accept_fill", a, 1);
    end
    send({16'hDEAD, 16'hBEEF}, {16'h0000, 16'h0000}, {16'h0000, 16'h0000}, 1, a);
    chk("t2_fifth_rejected", a, 0);
    low_cnt = 0;
    step(3);
    @(negedge CLK_i);
    chk("t3_stall_held", stall_o, 1);
    chk("t3_in_ready_full", in_ready_o, 0);
    chk("t3_res_valid", res_valid_o, 1);
    chk("t3_res_op1_held", res_op1_o, {16'h9111, 16'hA222});
    chk("t3_no_advance", low_cnt, 0);
    step(1);
    res_ready_i = 1;
    step(7);
    chk("t2_drain_low_cycles", low_cnt, 4);
    chk("t2_results", res_cnt, 8);
    chk("t2_sb_empty", sb.size(), 0);
    // finished with two beats queued
    stage_v = 2; res_ready_i = 0;
    send({16'h4400, 16'h4200}, {16'h0003, 16'h0007}, {16'h0100, 16'h0200}, 1, a);
    send({16'h4600, 16'h4800}, {16'h0001, 16'h0001}, {16'h0001, 16'h0001}, 0, a);
    send({16'h4A00, 16'h4C00}, {16'h0002, 16'h0002}, {16'h0002, 16'h0002}, 0, a);
    low_cnt = 0; d0 = done_cnt;
    finished_i = 1; res_ready_i = 1;
    k = 0;
    while (!done_o && k < 20) begin
      @(negedge CLK_i);
      k++;
    end
    chk("t4_done_seen", done_o, 1);
    chk("t4_dropped", dropped_o, 2);
    chk("t4_busy_low", busy_o, 0);
    chk("t4_no_advance", low_cnt, 0);
    step(3);
    finished_i = 0;
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_results", res_cnt, 9);
    chk("t4_sb_empty", sb.size(), 0);
    // reset mid-run
    start_i = 1; step(1); start_i = 0;
    @(negedge CLK_i);
    chk("t5_busy", busy_o, 1);
    chk("t5_dropped_cleared", dropped_o, 0);
    step(1);
    res_ready_i = 0; stage_v = 3;
    send({16'h1234, 16'h5678}, {16'h1111, 16'h1111}, {16'h2222, 16'h2222}, 0, a);
    for (int i = 0; i < 3; i++)
      send({16'h3000, 16'(16'h3100 + i)}, {16'h0001, 16'h0002}, {16'h0004, 16'h0008}, 0, a);
    d0 = done_cnt;
    RST_i = 1;
    @(negedge CLK_i);
    check_reset("t5");
    step(1);
    RST_i = 0;
    step(4);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_idle_busy", busy_o, 0);
    chk("t5_idle_stall", stall_o, 1);
    chk("t5_sb_empty", sb.size(), 0);
`ifdef STAGE2_FEEDER_PERF_EN
    res_ready_i = 1; stage_v = 4;
    start_i = 1; step(1); start_i = 0;
    for (int i = 0; i < 2; i++)
      send({16'h3C00, 16'(i)}, {16'h0001, 16'h0001}, {16'h0002, 16'h0002}, 1, a);
    step(2);
    for (int i = 0; i < 3; i++)
      send({16'h4000, 16'(i)}, {16'h0003, 16'h0003}, {16'h0004, 16'h0004}, 1, a);
    step(3);
    chk("perf_beat_cnt", beat_cnt_o, 5);
    chk("perf_stall_cnt_ge2", beat_cnt_o == 5 && stall_cnt_o >= 2, 1);
    chk("perf_sb_empty", sb.size(), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
